// File: rtl/audio_pkg.sv
// Shared audio sample-chain constants and sample types.
`timescale 1ns/1ps
package audio_pkg;
  localparam int SAMPLE_W    = 16;
  localparam int MCLK_PER_FS = 256;
  localparam int SLOT_W      = 32;

  typedef shortint sample_t;

  typedef struct packed {
    sample_t l;
    sample_t r;
  } stereo_t;
endpackage

// File: rtl/i2s_frame_counter.sv
// Frame counter for the I2S transmitter: one wrap of r_cnt is one stereo frame.
// Produces the next-state bit clock, frame clock and slot position so the top
// level can register its outputs as a function of the upcoming count.
`timescale 1ns/1ps
module i2s_frame_counter
  import audio_pkg::*;
#(
  parameter int MCLK_PER_BCLK = 4,
  parameter int SLOT_BITS     = SLOT_W,
  parameter int REQ_LEAD      = 4,
  localparam int CNT_W        = $clog2(MCLK_PER_FS),
  localparam int PH_W         = $clog2(MCLK_PER_BCLK),
  localparam int K_W          = $clog2(SLOT_BITS)
) (
  input  logic           i_mclk,
  input  logic           i_rst,
  output logic           o_bclk_next,
  output logic           o_lrc_next,
  output logic [K_W-1:0] o_k_next,
  output logic           o_latch,
  output logic           o_req_next
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;

  assign w_cnt_next = r_cnt + CNT_W'(1);

  // bclk is high for the upper half of each bit period (phase >= half).
  assign o_bclk_next = w_cnt_next[PH_W-1];
  // Top count bit selects the right slot (bit index >= SLOT_BITS).
  assign o_lrc_next  = w_cnt_next[CNT_W-1];
  // Slot position k = bit index modulo SLOT_BITS.
  assign o_k_next    = w_cnt_next[PH_W +: K_W];
  // Latch strobe marks the last count of the frame; the next edge wraps.
  assign o_latch     = &r_cnt;
  assign o_req_next  = (w_cnt_next == CNT_W'(MCLK_PER_FS - REQ_LEAD));

  // Free-running frame counter, wraps naturally at MCLK_PER_FS.
  always_ff @(posedge i_mclk or posedge i_rst) begin
    if (i_rst) r_cnt <= '0;
    else       r_cnt <= w_cnt_next;
  end

endmodule

// File: rtl/i2s_playback_tx.sv
// Philips I2S playback transmitter: latches a stereo frame at each frame
// boundary, serialises it MSB first one bclk after each pblrc edge, and tracks
// producer underruns with a saturating counter.
`timescale 1ns/1ps
module i2s_playback_tx
  import audio_pkg::*;
#(
  parameter int SAMPLE_BITS   = SAMPLE_W,
  parameter int SLOT_BITS     = SLOT_W,
  parameter int MCLK_PER_BCLK = 4,
  parameter int REQ_LEAD      = 4
) (
  input  logic                   mclk,
  input  logic                   rst,
  input  logic [SAMPLE_BITS-1:0] sample_l,
  input  logic [SAMPLE_BITS-1:0] sample_r,
  input  logic                   sample_valid,
  input  logic                   mute,
  output logic                   sample_req,
  output logic                   bclk,
  output logic                   pblrc,
  output logic                   pbdat,
  output logic                   underrun,
  output logic [15:0]            underrun_count
);

  localparam int K_W = $clog2(SLOT_BITS);

  if (MCLK_PER_BCLK * 2 * SLOT_BITS != MCLK_PER_FS) begin : g_bad_ratio
    $error("i2s_playback_tx: MCLK_PER_BCLK*2*SLOT_BITS must equal 256");
  end
  if ((MCLK_PER_BCLK < 2) || ((MCLK_PER_BCLK & (MCLK_PER_BCLK - 1)) != 0)) begin : g_bad_bclk
    $error("i2s_playback_tx: MCLK_PER_BCLK must be a power of two >= 2");
  end
  if (SAMPLE_BITS > SLOT_BITS - 1) begin : g_bad_width
    $error("i2s_playback_tx: SAMPLE_BITS must be <= SLOT_BITS-1");
  end
  if ((REQ_LEAD < 1) || (REQ_LEAD > 8)) begin : g_bad_lead
    $error("i2s_playback_tx: REQ_LEAD must be in 1..8");
  end

  logic                   w_bclk_next;
  logic                   w_lrc_next;
  logic [K_W-1:0]         w_k_next;
  logic                   w_latch;
  logic                   w_req_next;
  logic                   w_underrun_evt;
  logic                   w_pbdat_next;
  logic [SAMPLE_BITS-1:0] w_slot_word;
  logic [SAMPLE_BITS-1:0] r_shadow_l;
  logic [SAMPLE_BITS-1:0] r_shadow_r;

  // Saturating increment for the underrun counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Bit driven at slot position k: position 0 is the I2S one-bclk delay slot,
  // positions 1..SAMPLE_BITS carry the word MSB first, the rest pad with 0.
  function automatic logic slot_bit(input logic [SAMPLE_BITS-1:0] word,
                                    input logic [K_W-1:0]         k);
    logic [SLOT_BITS-1:0] pattern;
    pattern = SLOT_BITS'(word) << (SLOT_BITS - 1 - SAMPLE_BITS);
    return pattern[~k];
  endfunction

  i2s_frame_counter #(
    .MCLK_PER_BCLK (MCLK_PER_BCLK),
    .SLOT_BITS     (SLOT_BITS),
    .REQ_LEAD      (REQ_LEAD)
  ) u_cnt (
    .i_mclk      (mclk),
    .i_rst       (rst),
    .o_bclk_next (w_bclk_next),
    .o_lrc_next  (w_lrc_next),
    .o_k_next    (w_k_next),
    .o_latch     (w_latch),
    .o_req_next  (w_req_next)
  );

  // Serial data for the upcoming count comes from the slot's shadow word.
  // At the wrap edge k is 0, so the stale shadow word is never shown.
  assign w_slot_word    = w_lrc_next ? r_shadow_r : r_shadow_l;
  assign w_pbdat_next   = slot_bit(w_slot_word, w_k_next);
  assign w_underrun_evt = w_latch & ~sample_valid & ~mute;

  // Frame latch: mute wins, otherwise load valid data or repeat the last frame.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      r_shadow_l <= '0;
      r_shadow_r <= '0;
    end else if (w_latch) begin
      if (mute) begin
        r_shadow_l <= '0;
        r_shadow_r <= '0;
      end else if (sample_valid) begin
        r_shadow_l <= sample_l;
        r_shadow_r <= sample_r;
      end
    end
  end

  // Registered pin outputs, each equal to its function of the current count.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      bclk       <= 1'b0;
      pblrc      <= 1'b0;
      pbdat      <= 1'b0;
      sample_req <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      bclk       <= w_bclk_next;
      pblrc      <= w_lrc_next;
      pbdat      <= w_pbdat_next;
      sample_req <= w_req_next;
      underrun   <= w_underrun_evt;
    end
  end

  // Saturating underrun counter, advanced only on an underrun frame boundary.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst)                 underrun_count <= 16'h0000;
    else if (w_underrun_evt) underrun_count <= sat_inc16(underrun_count);
  end

endmodule

// File: tb/tb_i2s_playback_tx.sv
// Directed bench for i2s_playback_tx: frames are captured bit by bit and
// compared with hand-built I2S slot patterns.
`timescale 1ns/1ps
module tb_i2s_playback_tx;

  logic        mclk = 1'b0;
  logic        rst;
  logic [15:0] sample_l;
  logic [15:0] sample_r;
  logic        sample_valid;
  logic        mute;
  logic        sample_req;
  logic        bclk;
  logic        pblrc;
  logic        pbdat;
  logic        underrun;
  logic [15:0] underrun_count;

  int n_checks = 0;
  int n_err    = 0;

  i2s_playback_tx dut (
    .mclk           (mclk),
    .rst            (rst),
    .sample_l       (sample_l),
    .sample_r       (sample_r),
    .sample_valid   (sample_valid),
    .mute           (mute),
    .sample_req     (sample_req),
    .bclk           (bclk),
    .pblrc          (pblrc),
    .pbdat          (pbdat),
    .underrun       (underrun),
    .underrun_count (underrun_count)
  );

  always #5 mclk = ~mclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one mclk edge and sample 1 ns later.
  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  // Runs one whole frame starting in the cnt==0 state and ends in the next
  // cnt==0 state. Optionally changes the inputs while the count is chg_at.
  task automatic run_frame(input string tag, input logic [15:0] el, input logic [15:0] er,
                           input logic eur, input int chg_at,
                           input logic [15:0] cl, input logic [15:0] cr,
                           input logic cv, input logic cm);
    logic [63:0] cap;
    logic [63:0] exp_bits;
    int bm, lm, dm, rm, um;
    cap = '0;
    bm = 0; lm = 0; dm = 0; rm = 0; um = 0;
    for (int c = 0; c < 256; c++) begin
      if (c == chg_at) begin
        sample_l     = cl;
        sample_r     = cr;
        sample_valid = cv;
        mute         = cm;
      end
      if (bclk !== ((c % 4) >= 2)) bm++;
      if (pblrc !== (c >= 128)) lm++;
      if ((c % 4) == 0) cap[63 - c / 4] = pbdat;
      else if (pbdat !== cap[63 - c / 4]) dm++;
      if (sample_req !== (c == 252)) rm++;
      if (underrun !== ((c == 0) && eur)) um++;
      step();
    end
    exp_bits = {1'b0, el, 15'b0, 1'b0, er, 15'b0};
    chk({tag, "/pbdat"}, cap, exp_bits);
    chk({tag, "/bclk_errs"}, 64'(bm), 64'd0);
    chk({tag, "/pblrc_errs"}, 64'(lm), 64'd0);
    chk({tag, "/pbdat_unstable"}, 64'(dm), 64'd0);
    chk({tag, "/req_errs"}, 64'(rm), 64'd0);
    chk({tag, "/underrun_errs"}, 64'(um), 64'd0);
  endtask

  initial begin
    rst          = 1'b1;
    sample_l     = 16'h0000;
    sample_r     = 16'h0000;
    sample_valid = 1'b0;
    mute         = 1'b0;
    repeat (2) @(posedge mclk);
    #2;
    chk("rst/bclk", 64'(bclk), 64'd0);
    chk("rst/pblrc", 64'(pblrc), 64'd0);
    chk("rst/pbdat", 64'(pbdat), 64'd0);
    chk("rst/req", 64'(sample_req), 64'd0);
    chk("rst/underrun", 64'(underrun), 64'd0);
    chk("rst/count", 64'(underrun_count), 64'd0);

    @(negedge mclk);
    rst          = 1'b0;
    sample_l     = 16'hA5F0;
    sample_r     = 16'h0F0F;
    sample_valid = 1'b1;

    // First frame after reset transmits zeros.
    run_frame("f0", 16'h0000, 16'h0000, 1'b0, -1, 16'h0, 16'h0, 1'b0, 1'b0);
    // Basic serialisation; a change at cnt 10 must not disturb the frame.
    run_frame("f1", 16'hA5F0, 16'h0F0F, 1'b0, 10, 16'h1234, 16'h0F0F, 1'b1, 1'b0);
    // Late change at cnt 253 still makes the next latch.
    run_frame("f2", 16'h1234, 16'h0F0F, 1'b0, 253, 16'h7FFF, 16'h0F0F, 1'b1, 1'b0);
    // Drop valid before the boundary.
    run_frame("f3", 16'h7FFF, 16'h0F0F, 1'b0, 200, 16'h7FFF, 16'h0F0F, 1'b0, 1'b0);
    run_frame("f4_ur", 16'h7FFF, 16'h0F0F, 1'b1, -1, 16'h0, 16'h0, 1'b0, 1'b0);
    // Second underrun; then request mute with valid data present.
    run_frame("f5_ur", 16'h7FFF, 16'h0F0F, 1'b1, 100, 16'h8000, 16'h0F0F, 1'b1, 1'b1);
    chk("ur/count2", 64'(underrun_count), 64'd2);
    // Muted frame; release mute and present sign extremes.
    run_frame("f6_mute", 16'h0000, 16'h0000, 1'b0, 50, 16'h8000, 16'hFFFF, 1'b1, 1'b0);
    run_frame("f7_ext", 16'h8000, 16'hFFFF, 1'b0, -1, 16'h0, 16'h0, 1'b0, 1'b0);

    // Saturation: preload the counter at its ceiling, then underrun again.
    force dut.underrun_count = 16'hFFFF;
    #1;
    release dut.underrun_count;
    sample_valid = 1'b0;
    run_frame("f8", 16'h8000, 16'hFFFF, 1'b0, -1, 16'h0, 16'h0, 1'b0, 1'b0);
    chk("sat/underrun", 64'(underrun), 64'd1);
    chk("sat/count", 64'(underrun_count), 64'hFFFF);

    // Reset in the middle of the right slot.
    sample_l     = 16'hA5F0;
    sample_r     = 16'hFFFF;
    sample_valid = 1'b1;
    repeat (137) step();
    chk("mid/pbdat_pre", 64'(pbdat), 64'd1);
    chk("mid/pblrc_pre", 64'(pblrc), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("mid/bclk", 64'(bclk), 64'd0);
    chk("mid/pblrc", 64'(pblrc), 64'd0);
    chk("mid/pbdat", 64'(pbdat), 64'd0);
    chk("mid/req", 64'(sample_req), 64'd0);
    chk("mid/underrun", 64'(underrun), 64'd0);
    chk("mid/count", 64'(underrun_count), 64'd0);
    repeat (3) @(posedge mclk);
    @(negedge mclk);
    rst = 1'b0;
    run_frame("f9_post", 16'h0000, 16'h0000, 1'b0, -1, 16'h0, 16'h0, 1'b0, 1'b0);
    run_frame("f10_post", 16'hA5F0, 16'hFFFF, 1'b0, -1, 16'h0, 16'h0, 1'b0, 1'b0);
    chk("end/count", 64'(underrun_count), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
